// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator producing sync, data-enable, position and frame pulses.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   ce              pixel enable; one pixel advance per clk with ce=1
//   hsync, vsync    sync outputs at H_POL / V_POL polarity during the sync regions
//   de              high for visible pixels only
//   x, y            raw horizontal / vertical count of the pixel being presented
//   line_start      one-clk pulse at pixel 0 of every line
//   frame_start     one-clk pulse at pixel 0 of line 0
//   vblank          high on lines outside the visible area
//   frame_count     frames completed since reset, modulo 256
module vga_timing_gen #(
    parameter int CW       = 11,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic [7:0]    frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    if (CW < 1 || H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
        longint'(H_TOTAL - 1) > (longint'(1) << CW) - 1 ||
        longint'(V_TOTAL - 1) > (longint'(1) << CW) - 1) begin : g_bad_params
        $error("vga_timing_gen: invalid timing parameters");
    end
    // Region boundaries; the sync end is exclusive and always fits since the back porch is non-empty.
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
    logic [CW-1:0] hc, vc;
    logic          h_wrap, v_wrap;
    assign h_wrap = hc == H_LAST;
    assign v_wrap = vc == V_LAST;
    // Outputs decode the pre-increment counters, so they lag the counters by one enabled clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc          <= '0;
            vc          <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            vblank      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            line_start  <= ce && hc == '0;
            frame_start <= ce && hc == '0 && vc == '0;
            if (ce) begin
                hc     <= h_wrap ? '0 : hc + CW'(1);
                if (h_wrap)
                    vc <= v_wrap ? '0 : vc + CW'(1);
                x      <= hc;
                y      <= vc;
                de     <= hc < H_ACT && vc < V_ACT;
                hsync  <= (hc >= H_SS && hc < H_SE) ? H_POL : ~H_POL;
                vsync  <= (vc >= V_SS && vc < V_SE) ? V_POL : ~V_POL;
                vblank <= vc >= V_ACT;
                if (h_wrap && v_wrap)
                    frame_count <= frame_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a small 8x6 raster, normal and inverted hsync builds.
// Ports: none (top-level bench).
module tb_vga_timing_gen;
    localparam int CW = 11;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct {
        int x, y, hs, vs, de, ls, fs, vb, fc, hs2;
    } exp_t;

    logic          clk = 1'b0, rst = 1'b1, ce = 1'b0;
    logic          hsync, vsync, de, line_start, frame_start, vblank;
    logic          hsync2, vsync2, de2, line_start2, frame_start2, vblank2;
    logic [CW-1:0] x, y, x2, y2;
    logic [7:0]    frame_count, frame_count2;
    int            checks = 0, errors = 0;
    exp_t          q[$];
    exp_t          cur;
    int            pix, frames;

    always #5 clk = ~clk;

    vga_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .H_POL(1'b0), .V_POL(1'b0)) dut (
        .clk(clk), .rst(rst), .ce(ce), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .vblank(vblank), .frame_count(frame_count));

    vga_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .H_POL(1'b1), .V_POL(1'b0)) dut_hp (
        .clk(clk), .rst(rst), .ce(ce), .hsync(hsync2), .vsync(vsync2), .de(de2),
        .x(x2), .y(y2), .line_start(line_start2), .frame_start(frame_start2),
        .vblank(vblank2), .frame_count(frame_count2));

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a linear pixel index within the frame; position and region membership
    // follow from division/modulo and the porch/sync widths.
    task automatic step(input bit r, input bit c);
        int xx, yy;
        rst = r;
        ce  = c;
        @(posedge clk);
        if (r) begin
            pix    = 0;
            frames = 0;
            cur    = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        end else if (c) begin
            xx     = pix % HT;
            yy     = pix / HT;
            cur.x  = xx;
            cur.y  = yy;
            cur.de = (xx < HA && yy < VA) ? 1 : 0;
            cur.hs = (xx >= HA + HF && xx < HA + HF + HS) ? 0 : 1;
            cur.hs2 = 1 - cur.hs;
            cur.vs = (yy >= VA + VF && yy < VA + VF + VS) ? 0 : 1;
            cur.vb = (yy >= VA) ? 1 : 0;
            cur.ls = (xx == 0) ? 1 : 0;
            cur.fs = (pix == 0) ? 1 : 0;
            if (pix == FRAME - 1) frames = (frames + 1) % 256;
            cur.fc = frames;
            pix    = (pix + 1) % FRAME;
        end else begin
            cur.ls = 0;
            cur.fs = 0;
        end
        q.push_back(cur);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("x", int'(x), e.x);
            chk("y", int'(y), e.y);
            chk("de", int'(de), e.de);
            chk("hsync", int'(hsync), e.hs);
            chk("vsync", int'(vsync), e.vs);
            chk("vblank", int'(vblank), e.vb);
            chk("line_start", int'(line_start), e.ls);
            chk("frame_start", int'(frame_start), e.fs);
            chk("frame_count", int'(frame_count), e.fc);
            chk("hpol_hsync", int'(hsync2), e.hs2);
            chk("hpol_x", int'(x2), e.x);
            chk("hpol_de", int'(de2), e.de);
            chk("hpol_vsync", int'(vsync2), e.vs);
            chk("hpol_frame_start", int'(frame_start2), e.fs);
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 120; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) step(1'b0, 1'(i % 2 == 0));
        for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 3) != 0));
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0, 1'b1);
            found = cur.x == 6 && cur.y == 4;
        end
        chk("reach_x6_y4", int'(found), 1);
        #5;
        rst = 1'b1;
        #1;
        chk("async_hsync", int'(hsync), 1);
        chk("async_vsync", int'(vsync), 1);
        chk("async_de", int'(de), 0);
        chk("async_x", int'(x), 0);
        chk("async_hpol_hsync", int'(hsync2), 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 60; i++) step(1'b0, 1'($urandom_range(0, 1)));
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
